cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor and the successor to the 4-bit combinational CLA. The WIDTH-bit operation is split into GROUP-bit lookahead slices, one slice per pipeline stage, with the group carry registered between stages. A valid/ready handshake with full backpressure lets the block sit in a streaming datapath, and it adds a subtract mode and a signed-overflow flag.

---
 rtl/cla_pipe_adder.sv | 137 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module   : cla_pipe_adder
// Brief    : Pipelined carry-lookahead adder/subtractor, one GROUP-bit slice
//            per stage, valid/ready handshake with global stall.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // At least two slices are assumed (NG >= 2).
    localparam int NG = WIDTH / GROUP;

    // Returns {carry into slice MSB, slice carry out, slice sum}.
    function automatic logic [GROUP+1:0] f_cla(
        input logic [GROUP-1:0] fa,
        input logic [GROUP-1:0] fb,
        input logic             fc
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        logic             term;
        g    = fa & fb;
        p    = fa ^ fb;
        c    = '0;
        c[0] = fc;
        for (int i = 0; i < GROUP; i++) begin
            t = fc;
            for (int j = 0; j <= i; j++) t = t & p[j];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                t = t | term;
            end
            c[i+1] = t;
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             r_vld [NG];
    logic [WIDTH-1:0] r_sum [NG];
    logic             r_c   [NG];
    logic [WIDTH-1:0] r_a   [NG-1];
    logic [WIDTH-1:0] r_b   [NG-1];
    logic             r_ovf;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic [GROUP-1:0] w_op_a   [NG];
    logic [GROUP-1:0] w_op_b   [NG];
    logic             w_op_c   [NG];
    logic [WIDTH-1:0] w_sum_in [NG];
    logic [WIDTH-1:0] w_sum_nx [NG];
    logic [GROUP+1:0] w_res    [NG];

    assign w_adv    = !r_vld[NG-1] | out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub | cin;

    always_comb begin
        w_op_a[0]   = a[GROUP-1:0];
        w_op_b[0]   = w_b_eff[GROUP-1:0];
        w_op_c[0]   = w_c0;
        w_sum_in[0] = '0;
        for (int k = 1; k < NG; k++) begin
            w_op_a[k]   = r_a[k-1][GROUP-1:0];
            w_op_b[k]   = r_b[k-1][GROUP-1:0];
            w_op_c[k]   = r_c[k-1];
            w_sum_in[k] = r_sum[k-1];
        end
        for (int k = 0; k < NG; k++) begin
            w_res[k]    = f_cla(w_op_a[k], w_op_b[k], w_op_c[k]);
            w_sum_nx[k] = w_sum_in[k];
            w_sum_nx[k][k*GROUP +: GROUP] = w_res[k][GROUP-1:0];
        end
    end

    // Single global enable: every stage shifts or every stage holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NG; k++) begin
                r_vld[k] <= 1'b0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
            for (int k = 0; k < NG - 1; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < NG; k++) r_vld[k] <= r_vld[k-1];
            for (int k = 0; k < NG; k++) begin
                r_sum[k] <= w_sum_nx[k];
                r_c[k]   <= w_res[k][GROUP];
            end
            // Unresolved operand bits shift down so the next slice sits at the LSBs.
            r_a[0] <= a >> GROUP;
            r_b[0] <= w_b_eff >> GROUP;
            for (int k = 1; k < NG - 1; k++) begin
                r_a[k] <= r_a[k-1] >> GROUP;
                r_b[k] <= r_b[k-1] >> GROUP;
            end
            r_ovf <= w_res[NG-1][GROUP+1] ^ w_res[NG-1][GROUP];
        end
    end

    assign out_valid = r_vld[NG-1];
    assign sum       = r_sum[NG-1];
    assign cout      = r_c[NG-1];
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module   : tb_cla_pipe_adder
// Brief    : Self-checking bench for cla_pipe_adder against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc_cyc;
        int           acc_stl;
        logic         lit;
        logic [W-1:0] ls;
        logic         lc;
        logic         lo;
    } exp_t;

    exp_t         q[$];
    logic         lit_en = 1'b0;
    logic [W-1:0] lit_s  = '0;
    logic         lit_c  = 1'b0;
    logic         lit_o  = 1'b0;
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           stalls = 0;
    bit           head_seen = 0;
    bit           rst_seen = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_sum;
    logic         prev_c, prev_o, prev_v;
    bit           rdy_rand = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        exp_t   e;
        longint tot;
        longint r;
        if (!ms) begin
            tot = longint'(ma) + longint'(mb) + longint'(mc);
            e.s = W'(tot);
            e.c = tot[W];
            r   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        end else begin
            e.s = ma - mb;
            e.c = (ma >= mb);
            r   = longint'($signed(ma)) - longint'($signed(mb));
        end
        e.o = (r > 32767) || (r < -32768);
        e.acc_cyc = 0;
        e.acc_stl = 0;
        e.lit = 1'b0;
        e.ls  = '0;
        e.lc  = 1'b0;
        e.lo  = 1'b0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            head_seen  = 0;
            rst_seen   = 1;
            prev_stall = 0;
        end else begin
            if (rst_seen) begin
                chk("rst_out_valid", {31'd0, out_valid}, 0);
                chk("rst_sum", {16'd0, sum}, 0);
                chk("rst_cout", {31'd0, cout}, 0);
                chk("rst_ovf", {31'd0, ovf}, 0);
                chk("rst_in_ready", {31'd0, in_ready}, 1);
                rst_seen = 0;
            end
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                chk("stall_hold_valid", {31'd0, out_valid}, {31'd0, prev_v});
                chk("stall_hold_sum", {16'd0, sum}, {16'd0, prev_sum});
                chk("stall_hold_flags", {30'd0, cout, ovf}, {30'd0, prev_c, prev_o});
            end
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 0);
                end else begin
                    if (!head_seen) begin
                        chk("latency", cyc - q[0].acc_cyc - (stalls - q[0].acc_stl), NG);
                        head_seen = 1;
                        if (q[0].lit) begin
                            chk("model_pin_sum", {16'd0, q[0].s}, {16'd0, q[0].ls});
                            chk("model_pin_flags", {30'd0, q[0].c, q[0].o},
                                {30'd0, q[0].lc, q[0].lo});
                            chk("lit_sum", {16'd0, sum}, {16'd0, q[0].ls});
                            chk("lit_flags", {30'd0, cout, ovf}, {30'd0, q[0].lc, q[0].lo});
                        end
                    end
                    chk("sum", {16'd0, sum}, {16'd0, q[0].s});
                    chk("cout", {31'd0, cout}, {31'd0, q[0].c});
                    chk("ovf", {31'd0, ovf}, {31'd0, q[0].o});
                    if (out_ready) begin
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(a, b, cin, sub);
                e.acc_cyc = cyc;
                e.acc_stl = stalls;
                e.lit = lit_en;
                e.ls  = lit_s;
                e.lc  = lit_c;
                e.lo  = lit_o;
                q.push_back(e);
            end
            if (!in_ready) stalls++;
            prev_stall = out_valid && !out_ready;
            prev_v     = out_valid;
            prev_sum   = sum;
            prev_c     = cout;
            prev_o     = ovf;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input bit le, input logic [W-1:0] ls,
                        input logic lc, input logic lo);
        bit acc;
        bit done;
        done = 0;
        a = ta; b = tb_; cin = tc; sub = ts;
        lit_en = le; lit_s = ls; lit_c = lc; lit_o = lo;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("send_timeout", {31'd0, done}, 1);
        in_valid = 1'b0;
        lit_en   = 1'b0;
    endtask

    task automatic send_rnd(input logic ts);
        send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ts, 0, '0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        idle(6);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(16'h0001, 16'h000C, 1, 0, 1, 16'h000E, 0, 0);
        send(16'h0FFF, 16'h0001, 0, 0, 1, 16'h1000, 0, 0);
        send(16'hFFFF, 16'hFFFF, 1, 0, 1, 16'hFFFF, 1, 0);
        send(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1);
        send(16'h0005, 16'h0007, 1, 1, 1, 16'hFFFE, 0, 0);
        send(16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 1, 1);
        drain();

        rdy_rand = 1;
        for (int i = 0; i < 8; i++) send_rnd(1'($urandom_range(0, 1)));
        drain();
        for (int i = 0; i < 40; i++) begin
            send_rnd(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        rdy_rand = 0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            send_rnd(1'(i % 2));
            idle(1);
        end
        drain();

        for (int i = 0; i < 3; i++) send_rnd(1'($urandom_range(0, 1)));
        rst = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        idle(8);
        send(16'h0001, 16'h000C, 1, 0, 1, 16'h000E, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
